// File: rtl/loader_ram_bridge_if.sv
// Loader-to-RAM bridge bus: loader write stream, execute request, CPU arbitration
// input, and the RAM write port plus status outputs.
interface loader_ram_bridge_if #(
  parameter int ADDR = 16,
  parameter int DATA = 8
);
  logic            ld_download;
  logic            ld_wr;
  logic [ADDR-1:0] ld_addr;
  logic [DATA-1:0] ld_data;
  logic            exec_en;
  logic [ADDR-1:0] exec_addr;
  logic            cpu_cycle;
  logic            almost_full;
  logic            ram_we;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din;
  logic            cpu_hold;
  logic            busy;
  logic            overflow;
  logic [7:0]      checksum;

  // Loader / system side: drives requests, observes the bridge.
  modport master (
    output ld_download, ld_wr, ld_addr, ld_data, exec_en, exec_addr, cpu_cycle,
    input  almost_full, ram_we, ram_addr, ram_din, cpu_hold, busy, overflow, checksum
  );

  // Bridge side.
  modport slave (
    input  ld_download, ld_wr, ld_addr, ld_data, exec_en, exec_addr, cpu_cycle,
    output almost_full, ram_we, ram_addr, ram_din, cpu_hold, busy, overflow, checksum
  );
endinterface

// File: rtl/loader_ram_bridge.sv
// Loader-to-RAM bridge: buffers loader byte writes in a small FIFO, drains them
// into RAM in cycles the CPU leaves the port free, then patches the program entry
// vector (ENTRY_LSB / ENTRY_LSB+1) once the FIFO is empty.
// Optional macro LOADER_CHECKSUM_EN adds a modulo-256 sum of FIFO-sourced RAM
// writes on bus.checksum; without it the output is tied to zero.
module loader_ram_bridge #(
  parameter int              ADDR       = 16,
  parameter int              DATA       = 8,
  parameter int              DEPTH_LOG2 = 3,
  parameter logic [ADDR-1:0] ENTRY_LSB  = 16'h40DF
) (
  input  logic                 clock,
  input  logic                 reset,
  loader_ram_bridge_if.slave   bus
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_THR  = (DEPTH_LOG2+1)'(DEPTH-2);

  typedef enum logic [1:0] {IDLE, DRAIN, ENTRY_LO, ENTRY_HI} state_t;

  state_t                state_q, state_d;
  logic [ADDR-1:0]       entry_q, entry_d;
  logic [ADDR-1:0]       mem_addr_q [DEPTH];
  logic [DATA-1:0]       mem_data_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push, pop, drop;
  logic                  ent_we;
  logic [ADDR-1:0]       ent_addr;
  logic [DATA-1:0]       ent_data;
  logic                  ram_we_q;
  logic [ADDR-1:0]       ram_addr_q;
  logic [DATA-1:0]       ram_din_q;
  logic                  almost_full_q, cpu_hold_q, overflow_q, overflow_d;
  logic                  dl_q, dl_rise;
  logic                  busy;

  assign dl_rise = bus.ld_download & ~dl_q;
  assign busy    = (count_q != '0) || (state_q != IDLE);

  // FIFO push/pop decisions and next occupancy; a fresh push into an empty FIFO
  // is only visible to the pop logic a cycle later because pop looks at count_q.
  always_comb begin
    push    = bus.ld_wr && (count_q != DEPTH_C);
    drop    = bus.ld_wr && (count_q == DEPTH_C);
    pop     = (count_q != '0) && !bus.cpu_cycle && (state_q == IDLE || state_q == DRAIN);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = dl_rise ? drop : (overflow_q | drop);
  end

  // Sequencer: an execute request always wins and restarts the drain so the most
  // recent entry address is the one patched into the vector.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    ent_we   = 1'b0;
    ent_addr = ENTRY_LSB;
    ent_data = entry_q[DATA-1:0];
    if (bus.exec_en) begin
      entry_d = bus.exec_addr;
      state_d = DRAIN;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        DRAIN:    if (count_q == '0 && !push) state_d = ENTRY_LO;
        ENTRY_LO: if (!bus.cpu_cycle) begin
          ent_we  = 1'b1;
          state_d = ENTRY_HI;
        end
        ENTRY_HI: if (!bus.cpu_cycle) begin
          ent_we   = 1'b1;
          ent_addr = ENTRY_LSB + ADDR'(1);
          ent_data = entry_q[DATA +: DATA];
          state_d  = IDLE;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= bus.ld_addr;
      mem_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end

  // Control state, pointers, RAM write port and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      entry_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      almost_full_q <= 1'b0;
      cpu_hold_q    <= 1'b0;
      overflow_q    <= 1'b0;
      dl_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ram_we_q      <= pop | ent_we;
      if (pop) begin
        ram_addr_q <= mem_addr_q[rd_ptr_q];
        ram_din_q  <= mem_data_q[rd_ptr_q];
      end else if (ent_we) begin
        ram_addr_q <= ent_addr;
        ram_din_q  <= ent_data;
      end
      almost_full_q <= (count_d >= AF_THR);
      cpu_hold_q    <= bus.ld_download | busy;
      overflow_q    <= overflow_d;
      dl_q          <= bus.ld_download;
    end
  end

  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.almost_full = almost_full_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy;

`ifdef LOADER_CHECKSUM_EN
  logic       fifo_src_q;
  logic [7:0] checksum_q;

  // Running sum over FIFO-sourced writes only; entry-vector writes are skipped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_src_q <= 1'b0;
      checksum_q <= '0;
    end else begin
      fifo_src_q <= pop;
      if (dl_rise)                      checksum_q <= '0;
      else if (ram_we_q && fifo_src_q)  checksum_q <= checksum_q + ram_din_q[7:0];
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_loader_ram_bridge.sv
// Directed bench for loader_ram_bridge: latency, back-pressure/overflow, CPU
// stalls, entry-vector patching, exec re-latch, reset flush and checksum.
module tb_loader_ram_bridge;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [23:0] wq[$];

  loader_ram_bridge_if #(.ADDR(16), .DATA(8)) bus ();

  loader_ram_bridge dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Capture every RAM write strobe as {addr,data}, sampled mid-cycle.
  always @(negedge clock) if (bus.ram_we === 1'b1) wq.push_back({bus.ram_addr, bus.ram_din});

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int i);
    if (i < wq.size()) return {8'h00, wq[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.ld_wr = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    tick();
    bus.ld_wr = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max) begin tick(); n++; end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [9:0] alt;
    int popped;
    logic exp_we;
    bus.ld_download = 0; bus.ld_wr = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.exec_en = 0; bus.exec_addr = 0; bus.cpu_cycle = 0;
    tick(); tick();
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hold", bus.cpu_hold, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_cks", bus.checksum, 0);
    reset = 1'b0;
    tick();

    // Single write: strobe two cycles after ld_wr.
    wq.delete();
    wr(16'h5200, 8'hA5);
    chk("lat_n1_we", bus.ram_we, 0);
    tick();
    chk("lat_n2_we", bus.ram_we, 1);
    chk("lat_n2_addr", bus.ram_addr, 32'h5200);
    chk("lat_n2_din", bus.ram_din, 32'hA5);
    chk("lat_n2_hold", bus.cpu_hold, 1);
    tick();
    chk("lat_n3_we", bus.ram_we, 0);
    chk("lat_n3_hold", bus.cpu_hold, 0);

    // Burst of 10 with CPU holding the port: back-pressure then overflow.
    bus.ld_download = 1; tick();
    bus.cpu_cycle = 1;
    wq.delete();
    for (int i = 0; i < 10; i++) begin
      wr(16'h6000 + 16'(i), 8'h10 + 8'(i));
      if (i == 4) chk("burst_af_after5", bus.almost_full, 0);
      if (i == 5) chk("burst_af_after6", bus.almost_full, 1);
      if (i == 7) chk("burst_ovf_after8", bus.overflow, 0);
      if (i == 8) chk("burst_ovf_after9", bus.overflow, 1);
    end
    chk("burst_no_we", wq.size(), 0);
    bus.cpu_cycle = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("burst_cnt", wq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_wr%0d", i), qget(i), {8'h00, 16'h6000 + 16'(i), 8'h10 + 8'(i)});
    chk("burst_af_drained", bus.almost_full, 0);
    chk("burst_ovf_sticky", bus.overflow, 1);
    bus.ld_download = 0; tick();
    chk("ovf_hold_on_fall", bus.overflow, 1);
    bus.ld_download = 1; tick();
    chk("ovf_clr_on_rise", bus.overflow, 0);
    bus.ld_download = 0; tick(); tick();

    // Alternating CPU ownership: writes only follow cpu_cycle=0 cycles.
    bus.cpu_cycle = 1;
    for (int i = 0; i < 4; i++) wr(16'h7000 + 16'(i), 8'hC0 + 8'(i));
    wq.delete();
    alt = 10'b10_1010_1010;
    popped = 0;
    for (int k = 0; k < 10; k++) begin
      bus.cpu_cycle = ~alt[k];
      tick();
      exp_we = alt[k] && (popped < 4);
      if (exp_we) popped++;
      chk($sformatf("alt_we_k%0d", k), bus.ram_we, {31'd0, exp_we});
    end
    bus.cpu_cycle = 0;
    chk("alt_cnt", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_wr%0d", i), qget(i), {8'h00, 16'h7000 + 16'(i), 8'hC0 + 8'(i)});

    // Three writes then execute: data first, then entry vector low/high.
    wq.delete();
    wr(16'h5300, 8'h30); wr(16'h5301, 8'h31); wr(16'h5302, 8'h32);
    bus.exec_en = 1; bus.exec_addr = 16'h5200; tick(); bus.exec_en = 0;
    wait_idle(30, "exec_timeout");
    tick();
    chk("exec_cnt", wq.size(), 5);
    chk("exec_wr0", qget(0), 32'h53_0030);
    chk("exec_wr1", qget(1), 32'h53_0131);
    chk("exec_wr2", qget(2), 32'h53_0232);
    chk("exec_lo", qget(3), 32'h40_DF00);
    chk("exec_hi", qget(4), 32'h40_E052);
    chk("exec_busy", bus.busy, 0);
    chk("exec_hold", bus.cpu_hold, 0);

    // Re-execute while parked in ENTRY_LO: only the later address is written.
    wq.delete();
    bus.cpu_cycle = 1;
    bus.exec_en = 1; bus.exec_addr = 16'h1234; tick(); bus.exec_en = 0;
    tick(); tick();
    chk("reexec_parked", wq.size(), 0);
    bus.exec_en = 1; bus.exec_addr = 16'h6000; tick(); bus.exec_en = 0;
    bus.cpu_cycle = 0;
    wait_idle(30, "reexec_timeout");
    tick();
    chk("reexec_cnt", wq.size(), 2);
    chk("reexec_lo", qget(0), 32'h40_DF00);
    chk("reexec_hi", qget(1), 32'h40_E060);

    // Reset with five queued writes and a pending patch.
    bus.cpu_cycle = 1;
    for (int i = 0; i < 5; i++) wr(16'h5500 + 16'(i), 8'h50 + 8'(i));
    bus.exec_en = 1; bus.exec_addr = 16'h5555; tick(); bus.exec_en = 0;
    chk("pre_rst_busy", bus.busy, 1);
    wq.delete();
    reset = 1; #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_we", bus.ram_we, 0);
    chk("mid_rst_addr", bus.ram_addr, 0);
    chk("mid_rst_din", bus.ram_din, 0);
    chk("mid_rst_af", bus.almost_full, 0);
    chk("mid_rst_hold", bus.cpu_hold, 0);
    tick();
    reset = 0;
    bus.cpu_cycle = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_nowr", wq.size(), 0);
    chk("post_rst_busy", bus.busy, 0);

    // Checksum over FIFO writes; entry writes must not contribute.
    bus.ld_download = 1; tick();
    wr(16'h5600, 8'h01); wr(16'h5601, 8'hFF); wr(16'h5602, 8'h10);
    bus.ld_download = 0;
    for (int i = 0; i < 6; i++) tick();
    bus.exec_en = 1; bus.exec_addr = 16'hABCD; tick(); bus.exec_en = 0;
    wait_idle(30, "cks_timeout");
    tick(); tick();
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", bus.checksum, 32'h10);
`else
    chk("checksum_tied", bus.checksum, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
